// File: rtl/apple1_pkg.sv
// Apple-1 PIA shared definitions: register offsets and ASCII case-folding helpers.
// Latency: n/a (package). Backpressure: n/a.
// Contents: PIA_KBD/PIA_KBDCR/PIA_DSP/PIA_DSPCR offsets, lower-case range constants, to_upper().
package apple1_pkg;

    localparam logic [1:0] PIA_KBD   = 2'd0;
    localparam logic [1:0] PIA_KBDCR = 2'd1;
    localparam logic [1:0] PIA_DSP   = 2'd2;
    localparam logic [1:0] PIA_DSPCR = 2'd3;

    // ASCII 'a'..'z'; clearing bit 5 maps them onto 'A'..'Z'.
    localparam logic [7:0] ASCII_LC_FIRST = 8'h61;
    localparam logic [7:0] ASCII_LC_LAST  = 8'h7A;
    localparam int         ASCII_CASE_BIT = 5;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (c >= ASCII_LC_FIRST && c <= ASCII_LC_LAST) begin
            r[ASCII_CASE_BIT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard type-ahead FIFO: power-of-two depth, wrap-bit pointers, head shown combinationally.
// Latency: pushed key visible at the head one cycle after the push; pop takes effect at the edge.
// Backpressure: none internally; caller must not push when full unless popping in the same cycle.
// Ports: clk25, rst_n (sync, active-low), push/push_data, pop, head_data, empty, full.
module kbd_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk25,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible until a pointer moves.
    // On a full push+pop the write slot is the head being popped, read out before the edge.
    always_ff @(posedge clk25) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/apple1_pia.sv
// Apple-1 keyboard/display PIA (6820 subset) at $D010-$D013, CPU side gated by cpu_clken.
// Latency: dout 1 clk25 after addr/cs; kbd_rdy 1 cycle after kbd_valid; disp_valid 1 cycle after write.
// Backpressure: display valid/ready (DSP write dropped while busy); keyboard has none (newest wins / drop when full).
// Ports: clk25, rst_n (sync, active-low), cpu_clken, cs, we, addr, din, dout,
//        kbd_data/kbd_valid (keyboard in), disp_data/disp_valid/disp_ready (display out).
// Build option: define PIA_KBD_FIFO_EN for a KBD_FIFO_DEPTH-entry type-ahead buffer.
module apple1_pia
    import apple1_pkg::*;
#(
    parameter int DISP_BITS      = 7,
    parameter int KBD_FIFO_DEPTH = 4
) (
    input  logic                 clk25,
    input  logic                 rst_n,
    input  logic                 cpu_clken,
    input  logic                 cs,
    input  logic                 we,
    input  logic [1:0]           addr,
    input  logic [7:0]           din,
    output logic [7:0]           dout,
    input  logic [DISP_BITS-1:0] kbd_data,
    input  logic                 kbd_valid,
    output logic [DISP_BITS-1:0] disp_data,
    output logic                 disp_valid,
    input  logic                 disp_ready
);

    if ((KBD_FIFO_DEPTH < 2) || ((KBD_FIFO_DEPTH & (KBD_FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("KBD_FIFO_DEPTH must be a power of two, at least 2");
    end

    // ---------------------------------------------------------------- CPU access decode
    logic acc, rd_kbd, wr_kcr, wr_dsp, wr_dcr;

    assign acc    = cs & cpu_clken;
    assign rd_kbd = acc & ~we & (addr == PIA_KBD);
    assign wr_kcr = acc &  we & (addr == PIA_KBDCR);
    assign wr_dsp = acc &  we & (addr == PIA_DSP);
    assign wr_dcr = acc &  we & (addr == PIA_DSPCR);

    // Control registers and display data only carry the low seven bits of din.
    logic din_unused;
    assign din_unused = din[7];

    // ---------------------------------------------------------------- keyboard path
    logic [DISP_BITS-1:0] key_up;
    logic [DISP_BITS-1:0] key_head;
    logic                 kbd_rdy;

    assign key_up = DISP_BITS'(to_upper(8'(kbd_data)));

`ifdef PIA_KBD_FIFO_EN
    logic kbd_empty, kbd_full, kbd_push, kbd_pop;

    assign kbd_pop  = rd_kbd & ~kbd_empty;
    // Full FIFO drops new keys, except when a pop frees the slot in the same cycle.
    assign kbd_push = kbd_valid & (~kbd_full | kbd_pop);
    assign kbd_rdy  = ~kbd_empty;

    kbd_fifo #(
        .W     (DISP_BITS),
        .DEPTH (KBD_FIFO_DEPTH)
    ) u_kbd_fifo (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .push      (kbd_push),
        .push_data (key_up),
        .pop       (kbd_pop),
        .head_data (key_head),
        .empty     (kbd_empty),
        .full      (kbd_full)
    );
`else
    logic [DISP_BITS-1:0] key_q, key_d;
    logic                 kbd_rdy_q, kbd_rdy_d;

    // A key arriving with a KBD read wins: it is latched and kbd_rdy stays set.
    always_comb begin
        key_d     = key_q;
        kbd_rdy_d = kbd_rdy_q;
        if (rd_kbd) begin
            kbd_rdy_d = 1'b0;
        end
        if (kbd_valid) begin
            key_d     = key_up;
            kbd_rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            key_q     <= '0;
            kbd_rdy_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            kbd_rdy_q <= kbd_rdy_d;
        end
    end

    assign key_head = key_q;
    assign kbd_rdy  = kbd_rdy_q;
`endif

    // ---------------------------------------------------------------- control registers
    logic [6:0] kcr_q, kcr_d;
    logic [6:0] dcr_q, dcr_d;

    always_comb begin
        kcr_d = kcr_q;
        dcr_d = dcr_q;
        if (wr_kcr) kcr_d = din[6:0];
        if (wr_dcr) dcr_d = din[6:0];
    end

    // ---------------------------------------------------------------- display path
    logic [DISP_BITS-1:0] disp_data_q, disp_data_d;
    logic                 disp_valid_q, disp_valid_d;
    logic                 dsp_accept;

    // A write is taken when idle or when the pending character leaves this cycle,
    // so disp_data only ever changes outside a held valid.
    assign dsp_accept = wr_dsp & (~disp_valid_q | disp_ready);

    always_comb begin
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        if (disp_valid_q & disp_ready) begin
            disp_valid_d = 1'b0;
        end
        if (dsp_accept) begin
            disp_valid_d = 1'b1;
            disp_data_d  = din[DISP_BITS-1:0];
        end
    end

    // ---------------------------------------------------------------- read mux
    // Recomputed every clk25 so the CPU sees the pre-side-effect value on its acc cycle.
    logic [7:0] dout_q, dout_d;

    always_comb begin
        dout_d = 8'h00;
        if (cs) begin
            case (addr)
                PIA_KBD:   dout_d = {1'b1, key_head};
                PIA_KBDCR: dout_d = {kbd_rdy, kcr_q};
                PIA_DSP:   dout_d = {disp_valid_q, disp_data_q};
                default:   dout_d = {1'b0, dcr_q};
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            kcr_q        <= '0;
            dcr_q        <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            dout_q       <= 8'h00;
        end else begin
            kcr_q        <= kcr_d;
            dcr_q        <= dcr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            dout_q       <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;

endmodule
